// File: rtl/paddle_sched.sv
// rtl/paddle_sched.sv - two-player quadrature paddle step scheduler
// Turns direction requests into tick-paced encoder phase steps with acceleration and owner handover.
module paddle_sched #(
  parameter int CLKDIV      = 5500,
  parameter int ACCEL_STEPS = 8,
  parameter int GUARD_TICKS = 2
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic left0,
  input  logic right0,
  input  logic left1,
  input  logic right1,
  input  logic player_sel,
  input  logic enable,
  output logic enc_a,
  output logic enc_b,
  output logic busy,
  output logic owner
);

  typedef enum logic [1:0] {IDLE, SLOW, FAST, GUARD} state_t;

  localparam logic [15:0] TICK_MAX   = 16'(CLKDIV - 1);
  localparam logic [7:0]  ACCEL_CNT  = 8'(ACCEL_STEPS);
  localparam logic [3:0]  GUARD_LOAD = 4'(GUARD_TICKS);

  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [3:0]  guard_cnt_q, guard_cnt_d;
  logic        half_q, half_d;
  logic        dir_left_q, dir_left_d;
  logic        owner_q, owner_d;
  logic        busy_q, busy_d;

  logic        tick;
  logic        req_r, req_l, dir_valid;
  logic        do_step;
  logic [7:0]  step_inc;

  // Right walks 00->01->11->10; left walks the same ring backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] p, input logic left);
    logic [1:0] n;
    n = p;
    case (p)
      2'b00: n = left ? 2'b10 : 2'b01;
      2'b01: n = left ? 2'b00 : 2'b11;
      2'b11: n = left ? 2'b01 : 2'b10;
      2'b10: n = left ? 2'b11 : 2'b00;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_cnt_d  = step_cnt_q;
    guard_cnt_d = guard_cnt_q;
    half_d      = half_q;
    dir_left_d  = dir_left_q;
    owner_d     = owner_q;
    do_step     = 1'b0;

    tick       = (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;

    req_r     = owner_q ? right1 : right0;
    req_l     = owner_q ? left1  : left0;
    dir_valid = req_r ^ req_l;
    step_inc  = (step_cnt_q == 8'hFF) ? step_cnt_q : step_cnt_q + 8'd1;

    if (tick) begin
      if (state_q == GUARD) begin
        // Owner follows player_sel as it stands at expiry, not as it was at entry.
        guard_cnt_d = (guard_cnt_q == 4'd0) ? 4'd0 : guard_cnt_q - 4'd1;
        if (guard_cnt_q <= 4'd1) begin
          owner_d = player_sel;
          state_d = IDLE;
        end
      end else if (player_sel != owner_q) begin
        state_d     = GUARD;
        guard_cnt_d = GUARD_LOAD;
      end else if (enable) begin
        case (state_q)
          IDLE: begin
            if (dir_valid) begin
              state_d    = SLOW;
              step_cnt_d = 8'd0;
              half_d     = 1'b0;
              dir_left_d = req_l;
            end
          end
          SLOW, FAST: begin
            if (!dir_valid) begin
              state_d = IDLE;
            end else if (req_l != dir_left_q) begin
              state_d    = SLOW;
              step_cnt_d = 8'd0;
              half_d     = 1'b0;
              dir_left_d = req_l;
            end else if (state_q == FAST) begin
              do_step    = 1'b1;
              step_cnt_d = step_inc;
            end else if (half_q) begin
              do_step    = 1'b1;
              half_d     = 1'b0;
              step_cnt_d = step_inc;
              if (step_inc == ACCEL_CNT) state_d = FAST;
            end else begin
              half_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (do_step) phase_d = next_phase(phase_q, dir_left_q);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 16'd0;
      phase_q     <= 2'b00;
      step_cnt_q  <= 8'd0;
      guard_cnt_q <= 4'd0;
      half_q      <= 1'b0;
      dir_left_q  <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_q     <= phase_d;
      step_cnt_q  <= step_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      half_q      <= half_d;
      dir_left_q  <= dir_left_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
    end
  end

  assign enc_a = phase_q[1];
  assign enc_b = phase_q[0];
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule
